// File: rtl/decode_issue_stage.sv
// Decode/issue stage: field extraction, immediate sign-extension and one output register with valid/ready.
// Optional pending-write interlock enabled by defining DECODE_SCOREBOARD_EN.
module decode_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_instr,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [4:0]  d_rs,
  output logic [4:0]  d_rt,
  output logic [4:0]  d_rd,
  output logic        d_wr_en,
  output logic [31:0] d_imm,
  output logic [5:0]  d_opcode,
  output logic [5:0]  d_funct,
  output logic [4:0]  d_shamt,
  output logic        d_illegal
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 6;
  localparam int unsigned NREG = 32;

  logic [OPW-1:0]  f_opcode, f_funct;
  logic [RW-1:0]   f_rs, f_rt, f_rd, f_shamt;
  logic [XLEN-1:0] f_imm;

  assign f_opcode = i_instr[31:26];
  assign f_rs     = i_instr[25:21];
  assign f_rt     = i_instr[20:16];
  assign f_rd     = i_instr[15:11];
  assign f_shamt  = i_instr[10:6];
  assign f_funct  = i_instr[5:0];
  assign f_imm    = {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};

  logic          use_rs, use_rt, has_dest, illegal_c, wr_en_c, hazard, accept;
  logic [RW-1:0] dest, rd_c;

  // Operand usage and destination selection by opcode
  always_comb begin
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    has_dest  = 1'b0;
    dest      = f_rd;
    illegal_c = 1'b0;
    case (f_opcode)
      6'h00: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        has_dest = 1'b1;
      end
      6'h08, 6'h0C, 6'h0D, 6'h23: begin
        use_rs   = 1'b1;
        has_dest = 1'b1;
        dest     = f_rt;
      end
      6'h2B, 6'h04: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'h02: ;
      default: illegal_c = 1'b1;
    endcase
  end

  assign wr_en_c = has_dest && (dest != '0);
  assign rd_c    = has_dest ? dest : f_rd;

  logic            d_valid_q, d_wr_en_q, d_illegal_q;
  logic [RW-1:0]   d_rs_q, d_rt_q, d_rd_q, d_shamt_q;
  logic [OPW-1:0]  d_opcode_q, d_funct_q;
  logic [XLEN-1:0] d_imm_q;

  assign i_ready = !rst && !flush && !hazard && (!d_valid_q || d_ready);
  assign accept  = i_valid && i_ready;

`ifdef DECODE_SCOREBOARD_EN
  logic [NREG-1:0] sb_q, sb_d;

  // Registered pending bits only; a writeback this cycle releases the stall next cycle
  always_comb begin
    hazard = (use_rs && (f_rs != '0) && sb_q[f_rs]) ||
             (use_rt && (f_rt != '0) && sb_q[f_rt]) ||
             (has_dest && sb_q[dest]);
  end

  always_comb begin
    sb_d = sb_q;
    if (wb_en) sb_d[wb_addr] = 1'b0;
    // A flushed writer never reaches writeback, so release its pending bit here
    if (flush && d_valid_q && d_wr_en_q) sb_d[d_rd_q] = 1'b0;
    if (accept && wr_en_c) sb_d[dest] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end
`else
  logic unused_sb;
  assign hazard    = 1'b0;
  assign unused_sb = ^{wb_en, wb_addr, use_rs, use_rt, NREG[0]};
`endif

  // Output pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid_q   <= 1'b0;
      d_rs_q      <= '0;
      d_rt_q      <= '0;
      d_rd_q      <= '0;
      d_wr_en_q   <= 1'b0;
      d_imm_q     <= '0;
      d_opcode_q  <= '0;
      d_funct_q   <= '0;
      d_shamt_q   <= '0;
      d_illegal_q <= 1'b0;
    end else if (flush) begin
      d_valid_q <= 1'b0;
    end else if (accept) begin
      d_valid_q   <= 1'b1;
      d_rs_q      <= f_rs;
      d_rt_q      <= f_rt;
      d_rd_q      <= rd_c;
      d_wr_en_q   <= wr_en_c;
      d_imm_q     <= f_imm;
      d_opcode_q  <= f_opcode;
      d_funct_q   <= f_funct;
      d_shamt_q   <= f_shamt;
      d_illegal_q <= illegal_c;
    end else if (d_ready) begin
      d_valid_q <= 1'b0;
    end
  end

  assign d_valid   = d_valid_q;
  assign d_rs      = d_rs_q;
  assign d_rt      = d_rt_q;
  assign d_rd      = d_rd_q;
  assign d_wr_en   = d_wr_en_q;
  assign d_imm     = d_imm_q;
  assign d_opcode  = d_opcode_q;
  assign d_funct   = d_funct_q;
  assign d_shamt   = d_shamt_q;
  assign d_illegal = d_illegal_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage; expectations adapt to DECODE_SCOREBOARD_EN.
module tb_decode_issue_stage;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, i_valid, i_ready, flush, wb_en, d_valid, d_ready;
  logic [31:0] i_instr, d_imm;
  logic [4:0]  wb_addr, d_rs, d_rt, d_rd, d_shamt;
  logic        d_wr_en, d_illegal;
  logic [5:0]  d_opcode, d_funct;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .d_valid(d_valid), .d_ready(d_ready),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .d_wr_en(d_wr_en), .d_imm(d_imm),
    .d_opcode(d_opcode), .d_funct(d_funct), .d_shamt(d_shamt), .d_illegal(d_illegal)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  opcode, funct;
    logic [31:0] imm;
    logic        wr_en, illegal;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the instruction format table
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [5:0] op;
    logic       hd;
    logic [4:0] dst;
    op = ins[31:26];
    e.rs = ins[25:21]; e.rt = ins[20:16]; e.shamt = ins[10:6];
    e.opcode = op; e.funct = ins[5:0];
    e.imm = {{16{ins[15]}}, ins[15:0]};
    e.illegal = !(op inside {6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02});
    hd  = op inside {6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23};
    dst = (op == 6'h00) ? ins[15:11] : ins[20:16];
    e.wr_en = hd && (dst != 5'd0);
    e.rd = dst;
    return e;
  endfunction

  // One clock: drive, check ready/valid, pop/compare held result, push accepted one
  task automatic cycle(input logic v, input logic [31:0] ins, input logic dr, input logic fl,
                       input logic we, input logic [4:0] wa, input logic exp_rdy);
    exp_t e;
    i_valid = v; i_instr = ins; d_ready = dr; flush = fl; wb_en = we; wb_addr = wa;
    #1;
    check("i_ready", 32'(i_ready), 32'(exp_rdy));
    check("d_valid", 32'(d_valid), 32'(q.size() != 0));
    if (fl) q.delete();
    else if (dr && q.size() != 0) begin
      e = q.pop_front();
      check("d_rs", 32'(d_rs), 32'(e.rs));
      check("d_rt", 32'(d_rt), 32'(e.rt));
      check("d_wr_en", 32'(d_wr_en), 32'(e.wr_en));
      if (e.wr_en) check("d_rd", 32'(d_rd), 32'(e.rd));
      check("d_imm", d_imm, e.imm);
      check("d_opcode", 32'(d_opcode), 32'(e.opcode));
      check("d_funct", 32'(d_funct), 32'(e.funct));
      check("d_shamt", 32'(d_shamt), 32'(e.shamt));
      check("d_illegal", 32'(d_illegal), 32'(e.illegal));
    end
    if (v && exp_rdy) q.push_back(model(ins));
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] ADDI5  = 32'h2005FFFF;
  localparam logic [31:0] ADD6   = 32'h00A53020;
  localparam logic [31:0] RZERO  = 32'h00000020;
  localparam logic [31:0] LW7    = 32'h8C270004;
  localparam logic [31:0] ADD8   = 32'h00E74020;
  localparam logic [31:0] ADDI9  = 32'h20090007;
  localparam logic [31:0] ILL    = 32'hFC221234;
  localparam logic [31:0] ADDI3  = 32'h20030001;
  localparam logic [31:0] SW34   = 32'hAC830000;
  localparam logic [31:0] ADDI10 = 32'h200A0005;
  localparam logic [31:0] ADD11  = 32'h014A5820;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_instr = '0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; d_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_rd", 32'(d_rd), 32'd0);
    check("rst_d_rs", 32'(d_rs), 32'd0);
    check("rst_d_imm", d_imm, 32'd0);
    check("rst_d_wr_en", 32'(d_wr_en), 32'd0);
    check("rst_d_illegal", 32'(d_illegal), 32'd0);
    rst = 1'b0;

    // addi r5,r0,-1 then dependent add r6,r5,r5
    cycle(1'b1, ADDI5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    check("addi_d_valid", 32'(d_valid), 32'd1);
    check("addi_d_rd", 32'(d_rd), 32'd5);
    check("addi_d_wr_en", 32'(d_wr_en), 32'd1);
    check("addi_d_imm", d_imm, 32'hFFFFFFFF);
    if (SB) begin
      cycle(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      cycle(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      cycle(1'b1, ADD6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
      cycle(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    end else begin
      cycle(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    end
    check("add_d_rs", 32'(d_rs), 32'd5);
    check("add_d_rt", 32'(d_rt), 32'd5);
    check("add_d_rd", 32'(d_rd), 32'd6);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1);

    // Back-to-back R-type writing r0: never stalls
    for (int k = 0; k < 3; k++) cycle(1'b1, RZERO, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);

    // Held output is stable and blocks input while downstream stalls
    cycle(1'b1, ADDI9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1);

    // lw r7 flushed while held: its pending bit is dropped
    cycle(1'b1, LW7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle(1'b1, ADD8, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, ADD8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1);

    // Illegal opcode, then sw waiting on r3
    cycle(1'b1, ILL, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    check("ill_d_illegal", 32'(d_illegal), 32'd1);
    cycle(1'b1, ADDI3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    if (SB) begin
      cycle(1'b1, SW34, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
      cycle(1'b1, SW34, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    end else begin
      cycle(1'b1, SW34, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);

    // Reset while a writer is held clears the pipeline and pending bits
    cycle(1'b1, ADDI10, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    i_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst_mid_i_ready", 32'(i_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    check("rst_mid_d_valid", 32'(d_valid), 32'd0);
    check("rst_mid_d_rd", 32'(d_rd), 32'd0);
    cycle(1'b1, ADD11, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd11, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Registered instruction decode/issue stage placed directly upstream of the register file. It accepts 32-bit instructions from fetch, extracts the two source addresses (driven to the register file read ports) and the destination address (carried forward to writeback), sign-extends the immediate, and holds the result in one pipeline register with a valid/ready handshake. A 32-entry pending-write scoreboard interlocks issue against outstanding writes.

## Interface
- No parameters; the datapath is fixed at 32-bit instructions and 32 architectural registers.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  fetch presents an instruction
- i_ready  out  1  stage accepts i_instr this cycle
- i_instr  in  32  instruction word
- flush  in  1  drop the held instruction (branch redirect)
- wb_en  in  1  writeback completing
- wb_addr  in  5  register being written back
- d_valid  out  1  decoded instruction held
- d_ready  in  1  downstream consumes the held instruction
- d_rs, d_rt  out  5  source addresses, to register file read ports r1/r2
- d_rd  out  5  destination address, to register file write port r3 via writeback
- d_wr_en  out  1  instruction writes a register (never for dest 0)
- d_imm  out  32  sign-extended instr[15:0]
- d_opcode  out  6; d_funct  out  6; d_shamt  out  5
- d_illegal  out  1  unrecognised opcode

## Operation
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- Decode by opcode:
  - 0x00 R-type: sources rs and rt; dest rd.
  - 0x08 addi, 0x0C andi, 0x0D ori, 0x23 lw: source rs; dest rt.
  - 0x2B sw, 0x04 beq: sources rs and rt; no dest.
  - 0x02 j: no sources; no dest.
  - Anything else: d_illegal=1; no sources; no dest.
- Source addresses are output unchanged for every opcode. For non-source fields, d_rs/d_rt carry the raw bits but are excluded from the hazard check.
- d_wr_en = has_dest && dest != 0. When d_wr_en=0, d_rd carries the raw field.
- Scoreboard sb[31:0]:
  - Hazard when any used, nonzero source or the dest has its sb bit set. Both RAW and WAW stall.
  - sb[0] is never set.
- i_ready = !rst && !flush && !hazard && (!d_valid || d_ready).
- Accept (i_valid && i_ready):
  - Load the pipeline register and set d_valid=1.
  - If d_wr_en, set sb[dest].
- Consume (d_valid && d_ready) with no accept: d_valid=0.
- wb_en clears sb[wb_addr]. A set and a clear never target the same bit in one cycle, because WAW stalls.
- flush:
  - d_valid=0.
  - If the held instruction had d_wr_en, its sb bit is cleared, since it will never write back.
  - No accept occurs in a flush cycle.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on d_* after edge N, with d_valid=1.
- Full throughput of 1 per cycle when d_ready=1 and there is no hazard.
- The hazard check uses registered sb only; there is no same-cycle writeback bypass. A stalled instruction issues on the cycle after wb_en clears its bit.
- Outputs stay stable while d_valid && !d_ready.
- i_ready is combinational from i_instr, sb, d_valid, d_ready, flush and rst.
- Reset values:
  - d_valid=0, sb=0.
  - d_rs, d_rt, d_rd, d_opcode, d_funct, d_shamt = 0.
  - d_imm=0, d_wr_en=0, d_illegal=0.
- Reset mid-stall discards the held instruction and all pending bits.

## Configuration
- DECODE_SCOREBOARD_EN
  - Defined: scoreboard and interlock as specified above.
  - Undefined:
    - sb is not built and hazard is tied to 0.
    - wb_en and wb_addr are ignored.
    - i_ready = !rst && !flush && (!d_valid || d_ready).
    - Hazard avoidance becomes the responsibility of software.

## Test plan
- Reset, then send addi r5,r0,-1 (0x2005FFFF) -> after 1 cycle d_valid=1, d_rd=5, d_wr_en=1, d_imm=0xFFFFFFFF, sb[5]=1.
- Send add r6,r5,r5 directly after that addi -> i_ready=0 until the cycle after wb_en=1/wb_addr=5; then issues with d_rs=5, d_rt=5, d_rd=6.
- Send R-type with rd=0 (0x00000020) back-to-back with d_ready=1 -> d_wr_en=0, sb stays 0, no stall, one instruction per cycle.
- Issue lw r7 with d_ready=0, then assert flush -> d_valid=0 and sb[7]=0 next cycle; a following instruction using r7 issues without stall.
- Send opcode 0x3F -> d_illegal=1, d_wr_en=0, no scoreboard change. Then send sw r3,0(r4) while sb[3]=1 -> stalls.
- With DECODE_SCOREBOARD_EN undefined, repeat the second scenario -> no stall; add issues on the cycle after addi.
